// File: rtl/ftdi_cmd_proc.sv
// Byte-stream command processor: 'W' addr data writes a register, 'R' addr reads one back.
// Responses: 'A' ack, 'D' + data for reads, 'E' for a bad opcode.
`timescale 1ns/1ps
module ftdi_cmd_proc #(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [7:0]  VERSION        = 8'hA5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_tdata,
    input  logic         rx_tvalid,
    output logic         rx_tready,
    output logic [7:0]   tx_tdata,
    output logic         tx_tvalid,
    input  logic         tx_tready,
    output logic [119:0] regs_o,
    output logic [15:0]  cmd_count,
    output logic [7:0]   err_count
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] OpWrite = 8'h57;
    localparam logic [7:0] OpRead  = 8'h52;
    localparam logic [7:0] RspAck  = 8'h41;
    localparam logic [7:0] RspData = 8'h44;
    localparam logic [7:0] RspErr  = 8'h45;

    typedef enum logic [2:0] {
        StIdle,
        StGetAddr,
        StGetData,
        StResp0,
        StResp1
    } state_e;

    state_e          state_q, state_d;
    logic            rdy_en_q;
    logic            is_read_q, is_read_d;
    logic            is_err_q, is_err_d;
    logic [3:0]      addr_q, addr_d;
    logic [7:0]      rdata_q, rdata_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [15:0]     cmd_q, cmd_d;
    logic [7:0]      err_q, err_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [7:0]      regs_q [15];

    logic            rx_acc, tx_acc, in_get, timeout_hit, err_inc, wr_en;
    logic [7:0]      rd_sel;

    assign in_get      = (state_q == StGetAddr) || (state_q == StGetData);
    // rx_tready stays low until the first edge after reset release
    assign rx_tready   = rdy_en_q && (in_get || (state_q == StIdle));
    assign tx_tvalid   = (state_q == StResp0) || (state_q == StResp1);
    assign tx_tdata    = tx_data_q;
    assign cmd_count   = cmd_q;
    assign err_count   = err_q;
    assign rx_acc      = rx_tvalid && rx_tready;
    assign tx_acc      = tx_tvalid && tx_tready;
    assign timeout_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // Read mux indexed by the address byte itself so read data is captured on the same edge
    always_comb begin
        rd_sel = VERSION;
        for (int k = 0; k < 15; k++) begin
            if (rx_tdata[3:0] == 4'(k)) rd_sel = regs_q[k];
        end
    end

    always_comb begin
        regs_o = '0;
        for (int k = 0; k < 15; k++) regs_o[8*k +: 8] = regs_q[k];
    end

    always_comb begin
        state_d   = state_q;
        is_read_d = is_read_q;
        is_err_d  = is_err_q;
        addr_d    = addr_q;
        rdata_d   = rdata_q;
        tx_data_d = tx_data_q;
        cmd_d     = cmd_q;
        err_inc   = 1'b0;
        wr_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rx_acc) begin
                    if (rx_tdata == OpWrite || rx_tdata == OpRead) begin
                        is_read_d = (rx_tdata == OpRead);
                        is_err_d  = 1'b0;
                        state_d   = StGetAddr;
                    end else begin
                        is_err_d  = 1'b1;
                        tx_data_d = RspErr;
                        err_inc   = 1'b1;
                        state_d   = StResp0;
                    end
                end
            end
            StGetAddr: begin
                if (rx_acc) begin
                    addr_d = rx_tdata[3:0];
                    if (is_read_q) begin
                        rdata_d   = rd_sel;
                        tx_data_d = RspData;
                        state_d   = StResp0;
                    end else begin
                        state_d = StGetData;
                    end
                end else if (timeout_hit) begin
                    err_inc = 1'b1;
                    state_d = StIdle;
                end
            end
            StGetData: begin
                if (rx_acc) begin
                    wr_en     = (addr_q != 4'hF);
                    tx_data_d = RspAck;
                    state_d   = StResp0;
                end else if (timeout_hit) begin
                    err_inc = 1'b1;
                    state_d = StIdle;
                end
            end
            StResp0: begin
                if (tx_acc) begin
                    if (is_read_q && !is_err_q) begin
                        tx_data_d = rdata_q;
                        state_d   = StResp1;
                    end else begin
                        if (!is_err_q) cmd_d = cmd_q + 16'd1;
                        state_d = StIdle;
                    end
                end
            end
            StResp1: begin
                if (tx_acc) begin
                    cmd_d   = cmd_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

        if (in_get && !rx_acc && !timeout_hit) timer_d = timer_q + TW'(1);
        else                                   timer_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rdy_en_q  <= 1'b0;
            is_read_q <= 1'b0;
            is_err_q  <= 1'b0;
            addr_q    <= '0;
            rdata_q   <= '0;
            tx_data_q <= '0;
            cmd_q     <= '0;
            err_q     <= '0;
            timer_q   <= '0;
            for (int k = 0; k < 15; k++) regs_q[k] <= '0;
        end else begin
            state_q   <= state_d;
            rdy_en_q  <= 1'b1;
            is_read_q <= is_read_d;
            is_err_q  <= is_err_d;
            addr_q    <= addr_d;
            rdata_q   <= rdata_d;
            tx_data_q <= tx_data_d;
            cmd_q     <= cmd_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
            for (int k = 0; k < 15; k++) begin
                if (wr_en && addr_q == 4'(k)) regs_q[k] <= rx_tdata;
            end
        end
    end

endmodule
